rom_line_server: RTL and testbench
==================================

Name: rom_line_server

Overview:
- Responder end of the wide ROM read interface used by the HMC compute block.
- Stores 256 lines of 1024 bits.
- Filled after reset from a narrow 64-bit load stream. Once filled, it answers rom_addr with rom_data at one-cycle latency.
- Sits between the testbench/host loader and the HMC core, replacing a behavioural ROM.

Parameters:
- DATA_W, 1024, ROM line width in bits.
- ADDR_W, 8, line address width (2**ADDR_W lines).
- LOAD_W, 64, load-stream word width. DATA_W must be an integer multiple of LOAD_W.
- WPL, DATA_W/LOAD_W (16), load words per line; derived, not overridable.

Ports:
- clk1  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  load word present.
- load_data  input  LOAD_W  load word.
- load_ready  output  1  block accepts a load word this cycle.
- load_done  output  1  all lines written; serving reads.
- reload  input  1  single-cycle request to refill the ROM; honoured only in SERVE.
- rom_addr  input  ADDR_W  read line address.
- rom_data  output  DATA_W  registered read data.
- rom_valid  output  1  rom_data corresponds to the rom_addr of the previous cycle.
- rom_perr  output  1  parity error flag; present only with ROM_PARITY_EN.

Behaviour:
- Clock and reset:
  - Single clock clk1.
  - rst_n is asynchronous and active-low.
- Reset values:
  - state=LOAD, word_cnt=0, line_cnt=0, line buffer=0.
  - load_ready=0, load_done=0, rom_data=0, rom_valid=0, rom_perr=0.
  - Memory contents are not reset.
- States:
  - LOAD:
    - load_ready=1 from the first cycle after reset release.
    - A word is accepted when load_valid & load_ready.
    - Word k of a line goes to line bits [k*LOAD_W +: LOAD_W], so word 0 is the LSBs.
    - word_cnt increments on each accept and wraps from WPL-1 to 0.
    - On the accept with word_cnt==WPL-1, the assembled line (including that last word) is written to mem[line_cnt] in the same edge, and line_cnt increments.
    - On the write with line_cnt==2**ADDR_W-1, the next state is SERVE. line_cnt wraps to 0.
    - load_valid=0 stalls the counters; no timeout.
  - SERVE:
    - load_ready=0 and load_done=1.
    - Any load_valid is ignored and no counters move.
    - Each cycle: rom_data <= mem[rom_addr] and rom_valid <= 1. Latency is exactly one clk1 edge.
    - rom_addr is sampled every cycle, with no enable.
    - reload=1 sets next state LOAD and clears word_cnt, line_cnt, load_done, rom_valid and rom_data.
    - Memory keeps its old contents until each line is overwritten.
- Outputs during LOAD:
  - rom_valid=0 and rom_data holds 0.
  - rom_addr is ignored.
- Edge cases:
  - reload while in LOAD is ignored.
  - reload on the same edge as the final line write has no effect; the block enters SERVE.
  - rst_n asserted mid-load returns the block to LOAD with empty counters. A partially assembled line is discarded.
  - Back-to-back accepts every cycle are supported: 4096 cycles for a full fill.
  - Reading address 255 and then address 0 needs no special handling.

Optional Feature:
- Macro: ROM_PARITY_EN.
- With the macro defined:
  - Each stored line carries one extra even-parity bit, computed over the 1024 assembled bits at write time.
  - In SERVE, the read path recomputes parity from the stored data.
  - rom_perr is registered alongside rom_data: 1 when stored parity and recomputed parity differ, else 0.
  - rom_perr is 0 during LOAD and is cleared by reload.
  - rom_data is delivered unchanged regardless of rom_perr.
- Without the macro:
  - The rom_perr port and the parity storage do not exist.
  - Behaviour is otherwise identical.

Test Plan:
- Reset then fill: release rst_n and stream 4096 words with word value = {line[7:0], word[3:0]} zero-extended. Required:
  - load_ready=1 throughout.
  - load_done rises on the cycle after the 4096th accept.
  - load_ready falls in that same cycle.
- Read latency: after fill, rom_addr=0x00, 0x01, 0xFF, 0x00 on consecutive cycles. Required:
  - rom_data matches the expected lines one cycle later for each address.
  - rom_valid=1 from the first SERVE edge.
  - Line 0x01 word 3 reads 0x013 at bits [255:192].
- Stalled load: toggle load_valid randomly at 50% for the full fill. Required:
  - Identical memory contents to the unstalled fill.
  - load_done asserts only after exactly 4096 accepts.
- Reload: in SERVE, pulse reload, then refill with data XOR 0xFFFF_FFFF_FFFF_FFFF. Required:
  - load_done=0 and rom_valid=0 on the next cycle.
  - After the refill, reads return the inverted data.
- Mid-load reset: assert rst_n=0 after 1000 accepts, release it, then do a full fill. Required:
  - Outputs are 0 during reset.
  - load_done asserts only after 4096 fresh accepts.
  - All reads are correct.
- ROM_PARITY_EN: after fill, force-flip a single bit of mem[0x10] and read 0x10 and 0x11. Required:
  - rom_perr=1 for the 0x10 read.
  - rom_perr=0 for the 0x11 read.
  - rom_data for 0x10 shows the flipped bit.

Source files
------------

// File: rtl/rom_line_server.sv
// Wide-line ROM responder: fills 2**ADDR_W lines from a narrow load stream, then serves registered reads.
// Optional per-line even parity with a registered error flag when ROM_PARITY_EN is defined.
module rom_line_server #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 8,
  parameter int LOAD_W = 64
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [LOAD_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              reload,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_valid
`ifdef ROM_PARITY_EN
  ,
  output logic              rom_perr
`endif
);

  localparam int WPL   = DATA_W / LOAD_W;
  localparam int WCW   = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int LINES = 2 ** ADDR_W;

  typedef enum logic {
    S_LOAD,
    S_SERVE
  } state_t;

  state_t              state_q, state_d;
  logic [WCW-1:0]      word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   line_cnt_q, line_cnt_d;
  logic [DATA_W-1:0]   line_buf_q, line_buf_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic                accept;
  logic                last_word;
  logic                last_line;
  logic                wr_en;
  logic [DATA_W-1:0]   line_asm;

  logic [DATA_W-1:0]   mem [LINES];

`ifdef ROM_PARITY_EN
  logic                par_mem [LINES];
  logic                perr_q, perr_d;
`endif

  // The incoming word is merged into the buffer so the final word lands in the same write.
  always_comb begin
    line_asm = line_buf_q;
    line_asm[word_cnt_q*LOAD_W +: LOAD_W] = load_data;
  end

  assign accept    = (state_q == S_LOAD) & load_valid & ready_q;
  assign last_word = (word_cnt_q == WCW'(WPL - 1));
  assign last_line = (line_cnt_q == ADDR_W'(LINES - 1));
  assign wr_en     = accept & last_word;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    line_buf_d = line_buf_q;
    ready_d    = ready_q;
    done_d     = done_q;
    rdata_d    = rdata_q;
    rvalid_d   = rvalid_q;
    case (state_q)
      S_LOAD: begin
        ready_d  = 1'b1;
        done_d   = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        if (accept) begin
          line_buf_d = line_asm;
          word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
          if (last_word) begin
            line_cnt_d = line_cnt_q + 1'b1;
            if (last_line) begin
              state_d = S_SERVE;
              ready_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_SERVE: begin
        ready_d  = 1'b0;
        done_d   = 1'b1;
        rvalid_d = 1'b1;
        rdata_d  = mem[rom_addr];
        if (reload) begin
          state_d    = S_LOAD;
          word_cnt_d = '0;
          line_cnt_d = '0;
          ready_d    = 1'b1;
          done_d     = 1'b0;
          rvalid_d   = 1'b0;
          rdata_d    = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

`ifdef ROM_PARITY_EN
  // Stored parity is compared against parity recomputed from the stored line on every read.
  always_comb begin
    perr_d = 1'b0;
    if (state_q == S_SERVE && !reload) begin
      perr_d = par_mem[rom_addr] ^ (^mem[rom_addr]);
    end
  end
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
      line_buf_q <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
`ifdef ROM_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
      line_buf_q <= line_buf_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
`ifdef ROM_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  // Line storage is deliberately not reset; contents survive reload until overwritten.
  always_ff @(posedge clk1) begin
    if (wr_en) begin
      mem[line_cnt_q] <= line_asm;
`ifdef ROM_PARITY_EN
      par_mem[line_cnt_q] <= ^line_asm;
`endif
    end
  end

  assign load_ready = ready_q;
  assign load_done  = done_q;
  assign rom_data   = rdata_q;
  assign rom_valid  = rvalid_q;
`ifdef ROM_PARITY_EN
  assign rom_perr   = perr_q;
`endif

endmodule

// File: tb/tb_rom_line_server.sv
// Scoreboard bench for rom_line_server: fills, reads, reload, mid-load reset, optional parity fault.
module tb_rom_line_server;

  logic          clk1;
  logic          rst_n;
  logic          load_valid;
  logic [63:0]   load_data;
  logic          load_ready;
  logic          load_done;
  logic          reload;
  logic [7:0]    rom_addr;
  logic [1023:0] rom_data;
  logic          rom_valid;
`ifdef ROM_PARITY_EN
  logic          rom_perr;
`endif

  rom_line_server dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .reload     (reload),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_valid  (rom_valid)
`ifdef ROM_PARITY_EN
    ,
    .rom_perr   (rom_perr)
`endif
  );

  typedef struct {
    logic [1023:0] data;
    logic          perr;
    logic [7:0]    addr;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [1023:0] ref_mem [256];
  logic          ref_perr [256];
  int            n_chk  = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b1;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] word_val(input int line, input int w, input bit inv);
    logic [63:0] v;
    v = {52'd0, 8'(line), 4'(w)};
    return inv ? ~v : v;
  endfunction

  function automatic logic [1023:0] line_val(input int line, input bit inv);
    logic [1023:0] l;
    for (int w = 0; w < 16; w++) l[w*64 +: 64] = word_val(line, w, inv);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Streams n words starting from word 0; each valid cycle is expected to be accepted.
  task automatic fill(input int n, input bit inv, input bit stall, input bit rl);
    int acc = 0;
    int cyc = 0;
    bit v;
    while (acc < n && cyc < 20000) begin
      v          = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      load_valid = v;
      load_data  = word_val(acc / 16, acc % 16, inv);
      reload     = rl ? ((acc == 4095 && v) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      #3;
      chk("load_ready_during_fill", 64'(load_ready), 64'd1);
      chk("load_done_during_fill", 64'(load_done), 64'd0);
      @(posedge clk1);
      #1;
      cyc++;
      if (v) acc++;
    end
    load_valid = 1'b0;
    reload     = 1'b0;
    if (acc < n) chk("fill_cycle_budget_accepts", 64'(acc), 64'(n));
    for (int l = 0; l < acc / 16; l++) begin
      ref_mem[l]  = line_val(l, inv);
      ref_perr[l] = 1'b0;
    end
    if (n == 4096) begin
      chk("load_done_after_fill", 64'(load_done), 64'd1);
      chk("load_ready_after_fill", 64'(load_ready), 64'd0);
      chk("rom_valid_first_serve_cycle", 64'(rom_valid), 64'd0);
    end
  endtask

  task automatic rd(input logic [7:0] a);
    exp_t e;
    rom_addr = a;
    e.data   = ref_mem[a];
    e.perr   = ref_perr[a];
    e.addr   = a;
    q.push_back(e);
    @(posedge clk1);
    #1;
  endtask

  task automatic sweep();
    for (int a = 0; a < 256; a++) rd(8'(a));
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk1);
    #1;
    reload = 1'b0;
    chk("reload_load_done", 64'(load_done), 64'd0);
    chk("reload_rom_valid", 64'(rom_valid), 64'd0);
    chk("reload_rom_data_nonzero", 64'(|rom_data), 64'd0);
    chk("reload_load_ready", 64'(load_ready), 64'd1);
  endtask

  always @(negedge clk1) begin
    if (mon_en && rom_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rom_valid: got 1 required 0 (no read outstanding)");
      end else begin
        int dw;
        mon_e = q.pop_front();
        dw    = -1;
        for (int k = 15; k >= 0; k--) if (rom_data[k*64 +: 64] !== mon_e.data[k*64 +: 64]) dw = k;
        n_chk++;
        if (dw >= 0) begin
          n_fail++;
          $display("FAIL rom_data addr %0h word %0d: got %0h required %0h",
                   mon_e.addr, dw, rom_data[dw*64 +: 64], mon_e.data[dw*64 +: 64]);
        end
`ifdef ROM_PARITY_EN
        chk("rom_perr", 64'(rom_perr), 64'(mon_e.perr));
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = '0;
      ref_perr[i] = 1'b0;
    end
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    reload     = 1'b0;
    rom_addr   = '0;
    repeat (3) @(posedge clk1);
    #1;
    chk("reset_load_ready", 64'(load_ready), 64'd0);
    chk("reset_load_done", 64'(load_done), 64'd0);
    chk("reset_rom_valid", 64'(rom_valid), 64'd0);
    chk("reset_rom_data_nonzero", 64'(|rom_data), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("load_ready_before_first_edge", 64'(load_ready), 64'd0);
    @(posedge clk1);
    #1;

    // Back-to-back fill, then directed and random reads.
    fill(4096, 1'b0, 1'b0, 1'b0);
    rd(8'h00);
    rd(8'h01);
    chk("line01_word3", rom_data[255:192], 64'h13);
    rd(8'hFF);
    rd(8'h00);
    for (int i = 0; i < 40; i++) rd(8'($urandom_range(0, 255)));

    // Reload with inverted data; reload toggles in LOAD and lands on the final write.
    do_reload();
    fill(4096, 1'b1, 1'b0, 1'b1);
    sweep();

    // Partial fill interrupted by reset, then a stalled full fill.
    do_reload();
    fill(1000, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midreset_load_ready", 64'(load_ready), 64'd0);
    chk("midreset_load_done", 64'(load_done), 64'd0);
    chk("midreset_rom_valid", 64'(rom_valid), 64'd0);
    chk("midreset_rom_data_nonzero", 64'(|rom_data), 64'd0);
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    fill(4096, 1'b0, 1'b1, 1'b0);
    sweep();

`ifdef ROM_PARITY_EN
    dut.mem[16][37] = ~dut.mem[16][37];
    ref_mem[16][37] = ~ref_mem[16][37];
    ref_perr[16]    = 1'b1;
    rd(8'h10);
    rd(8'h11);
`endif

    @(negedge clk1);
    #1;
    mon_en = 1'b0;
    chk("reads_outstanding_at_end", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
